// File: rtl/intan_fifo_bank.sv
// Multi-channel Intan read-path writer bank: one fs/fd handshake fills CH_NUM per-channel FIFOs
// with a 2-byte ID header and a counting data payload. Define INTAN_FIFO_SUM_EN for an XOR trailer byte.
module intan_fifo_bank #(
  parameter int CH_NUM = 4,
  parameter int DW     = 8,
  parameter int AW     = 9,
  parameter int LEN_W  = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fs,
  output logic                    fd,
  input  logic [CH_NUM*LEN_W-1:0] ch_len,
  input  logic [CH_NUM*16-1:0]    ch_id,
  input  logic [CH_NUM-1:0]       rxen,
  output logic [CH_NUM*DW-1:0]    rxd,
  output logic [CH_NUM-1:0]       full,
  output logic [CH_NUM-1:0]       empty,
  output logic                    err,
  output logic [7:0]              so
);

  typedef enum logic [1:0] {
    G_IDLE = 2'd0,
    G_LOAD = 2'd1,
    G_RUN  = 2'd2,
    G_DONE = 2'd3
  } g_state_e;

  typedef enum logic [2:0] {
    CH_IDLE,
    CH_HEAD0,
    CH_HEAD1,
    CH_DATA,
    CH_DONE
`ifdef INTAN_FIFO_SUM_EN
    , CH_SUM
`endif
  } ch_state_e;

  g_state_e          r_g_state;
  logic              r_fs_d;
  logic [CH_NUM-1:0] w_ch_done;
  logic              w_fs_rise;
  logic              w_underflow;

  assign w_fs_rise   = fs & ~r_fs_d;
  assign w_underflow = |(rxen & empty);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_g_state <= G_IDLE;
      r_fs_d    <= 1'b0;
      fd        <= 1'b0;
      err       <= 1'b0;
      so        <= 8'd0;
    end else begin
      r_fs_d <= fs;
      // A second fs rising edge mid-frame is flagged but otherwise ignored.
      if (w_underflow || (w_fs_rise && (r_g_state == G_LOAD || r_g_state == G_RUN)))
        err <= 1'b1;
      case (r_g_state)
        G_IDLE: if (fs) begin
          r_g_state <= G_LOAD;
          so        <= 8'd1;
        end
        G_LOAD: begin
          r_g_state <= G_RUN;
          so        <= 8'd2;
        end
        G_RUN: if (&w_ch_done) begin
          r_g_state <= G_DONE;
          so        <= 8'd3;
          fd        <= 1'b1;
        end
        G_DONE: if (!fs) begin
          r_g_state <= G_IDLE;
          so        <= 8'd0;
          fd        <= 1'b0;
        end
        default: r_g_state <= G_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
    ch_state_e        r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [7:0]       r_id_lo;
    logic             r_wr_en;
    logic [DW-1:0]    r_wr_data;
`ifdef INTAN_FIFO_SUM_EN
    logic [DW-1:0]    r_sum;
`endif
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [DW-1:0]    r_mem [2**AW];
    logic [DW-1:0]    r_rxd;
    logic [LEN_W-1:0] w_len_in;
    logic [15:0]      w_id_in;
    logic             w_full;
    logic             w_empty;
    logic             w_wr;
    logic             w_rd;

    assign w_len_in = ch_len[gi*LEN_W +: LEN_W];
    assign w_id_in  = ch_id[gi*16 +: 16];
    assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty  = (r_wptr == r_rptr);
    assign w_wr     = r_wr_en & ~w_full;
    assign w_rd     = rxen[gi] & ~w_empty;

    // Writer: state, write enable and write data advance together; a full FIFO freezes all of them.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state   <= CH_IDLE;
        r_len     <= '0;
        r_cnt     <= '0;
        r_id_lo   <= '0;
        r_wr_en   <= 1'b0;
        r_wr_data <= '0;
`ifdef INTAN_FIFO_SUM_EN
        r_sum     <= '0;
`endif
      end else begin
        case (r_state)
          CH_IDLE: if (r_g_state == G_LOAD) begin
            r_len   <= w_len_in;
            r_id_lo <= w_id_in[7:0];
            r_cnt   <= '0;
`ifdef INTAN_FIFO_SUM_EN
            r_sum   <= '0;
`endif
            if (w_len_in == '0) begin
              r_state <= CH_DONE;
            end else begin
              r_state   <= CH_HEAD0;
              r_wr_en   <= 1'b1;
              r_wr_data <= DW'(w_id_in[15:8]);
            end
          end
          CH_HEAD0: if (!w_full) begin
            r_state   <= CH_HEAD1;
            r_wr_data <= DW'(r_id_lo);
          end
          CH_HEAD1: if (!w_full) begin
            r_state   <= CH_DATA;
            r_wr_data <= '0;
          end
          CH_DATA: if (!w_full) begin
            if (r_cnt == r_len - 1'b1) begin
`ifdef INTAN_FIFO_SUM_EN
              r_state   <= CH_SUM;
              r_wr_data <= r_sum ^ r_wr_data;
`else
              r_state   <= CH_DONE;
              r_wr_en   <= 1'b0;
`endif
            end else begin
              r_cnt     <= r_cnt + 1'b1;
              r_wr_data <= DW'(r_cnt + 1'b1);
            end
`ifdef INTAN_FIFO_SUM_EN
            r_sum <= r_sum ^ r_wr_data;
`endif
          end
`ifdef INTAN_FIFO_SUM_EN
          CH_SUM: if (!w_full) begin
            r_state <= CH_DONE;
            r_wr_en <= 1'b0;
          end
`endif
          CH_DONE: if (r_g_state == G_IDLE) r_state <= CH_IDLE;
          default: r_state <= CH_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_rxd  <= '0;
      end else begin
        if (w_wr) r_wptr <= r_wptr + 1'b1;
        if (w_rd) begin
          r_rptr <= r_rptr + 1'b1;
          r_rxd  <= r_mem[r_rptr[AW-1:0]];
        end
      end
    end

    // NOTE: storage has no reset; pointer reset alone empties the FIFO and keeps it RAM-inferable.
    always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr[AW-1:0]] <= r_wr_data;
    end

    assign w_ch_done[gi]       = (r_state == CH_DONE);
    assign full[gi]            = w_full;
    assign empty[gi]           = w_empty;
    assign rxd[gi*DW +: DW]    = r_rxd;
  end

endmodule

// File: tb/tb_intan_fifo_bank.sv
// Directed bench for intan_fifo_bank: a 4-channel default instance and a 1-channel 16-deep
// instance for backpressure. Honours INTAN_FIFO_SUM_EN when defined at compile time.
module tb_intan_fifo_bank;
  localparam int CH = 4;
  localparam int LW = 12;
`ifdef INTAN_FIFO_SUM_EN
  localparam int TRL = 1;
`else
  localparam int TRL = 0;
`endif

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int         ch;
    logic [7:0] exp;
  } rd_vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             fs, fd, err;
  logic [CH*LW-1:0] ch_len;
  logic [CH*16-1:0] ch_id;
  logic [CH-1:0]    rxen, full, empty;
  logic [CH*8-1:0]  rxd;
  logic [7:0]       so;

  logic        s_fs, s_fd, s_err;
  logic [11:0] s_len;
  logic [15:0] s_id;
  logic [0:0]  s_rxen, s_full, s_empty;
  logic [7:0]  s_rxd, s_so;

  intan_fifo_bank #(.CH_NUM(CH), .DW(8), .AW(9), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .fs(fs), .fd(fd), .ch_len(ch_len), .ch_id(ch_id),
    .rxen(rxen), .rxd(rxd), .full(full), .empty(empty), .err(err), .so(so)
  );

  intan_fifo_bank #(.CH_NUM(1), .DW(8), .AW(4), .LEN_W(12)) dut_small (
    .clk(clk), .rst(rst), .fs(s_fs), .fd(s_fd), .ch_len(s_len), .ch_id(s_id),
    .rxen(s_rxen), .rxd(s_rxd), .full(s_full), .empty(s_empty), .err(s_err), .so(s_so)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected byte stream of one channel frame: ID header, counting payload, optional XOR trailer.
  function automatic bq_t frame_bytes(input logic [15:0] id, input int len);
    bq_t        q;
    logic [7:0] x = 8'h00;
    q.push_back(id[15:8]);
    q.push_back(id[7:0]);
    for (int k = 0; k < len; k++) begin
      q.push_back(8'(k));
      x ^= 8'(k);
    end
    if (TRL == 1) q.push_back(x);
    return q;
  endfunction

  task automatic read_byte(input int ch, input logic [7:0] exp, input string name);
    rxen[ch] = 1'b1;
    tick();
    rxen[ch] = 1'b0;
    check(name, rxd[ch*8 +: 8], exp);
  endtask

  task automatic drain_ch(input int ch, input logic [15:0] id, input int len, input string tag);
    bq_t e;
    e = frame_bytes(id, len);
    for (int i = 0; i < e.size(); i++) read_byte(ch, e[i], $sformatf("%s_b%0d", tag, i));
    check({tag, "_empty"}, empty[ch], 1'b1);
  endtask

  task automatic wait_fd(input string name, input int bound, output int n);
    n = 0;
    while (!fd && n < bound) begin
      tick();
      n++;
    end
    check(name, fd, 1'b1);
  endtask

  task automatic run_frame(input string tag, output int n);
    fs = 1'b1;
    wait_fd({tag, "_fd_rise"}, 2000, n);
    fs = 1'b0;
    tick();
    check({tag, "_fd_fall"}, fd, 1'b0);
  endtask

  task automatic s_read(input logic [7:0] exp, input string name);
    int w = 0;
    while (s_empty[0] && w < 20) begin
      tick();
      w++;
    end
    s_rxen = 1'b1;
    tick();
    s_rxen = 1'b0;
    check(name, s_rxd, exp);
  endtask

  initial begin
    rd_vec_t tbl[$];
    bq_t     e;
    int      n, idx;
    logic    pend, full_seen;

    // Basic-frame readout table: channel 1 (len 0x20) then channels 2 and 3 (len 0x40).
    for (int ch = 1; ch < CH; ch++) begin
      e = frame_bytes({2{8'h11 * 8'(ch + 1)}}, (ch == 1) ? 32 : 64);
      for (int i = 0; i < e.size(); i++) tbl.push_back('{ch: ch, exp: e[i]});
    end

    rst = 1'b1; fs = 1'b0; rxen = '0; ch_len = '0; ch_id = '0;
    s_fs = 1'b0; s_rxen = '0; s_len = '0; s_id = '0;
    #12;
    check("rst_fd", fd, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_so", so, 8'h00);
    check("rst_full", full, 4'h0);
    check("rst_empty", empty, 4'hF);
    check("rst_rxd", rxd, 32'h0);
    check("rst_small_empty", s_empty, 1'b1);
    tick();
    rst = 1'b0;
    tick();

    // Basic frame; inputs are scrambled right after LOAD to prove they were latched.
    ch_len = {12'h040, 12'h040, 12'h020, 12'h000};
    ch_id  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    fs = 1'b1;
    n = 0;
    while (n < 200) begin
      tick();
      n++;
      if (n == 1) check("basic_so_load", so, 8'h01);
      if (n == 2) begin
        check("basic_so_run", so, 8'h02);
        check("basic_empty_head0", empty, 4'hF);
        ch_len = '1;
        ch_id  = '0;
      end
      if (n == 3) check("basic_empty_first_wr", empty, 4'b0001);
      if (fd) break;
    end
    // 66 writes on edges 3..68 (+trailer), channels DONE on the last write edge, fd one edge later.
    check("basic_fd_cycle", n, 69 + TRL);
    check("basic_so_done", so, 8'h03);
    check("basic_ch0_empty", empty, 4'b0001);
    fs = 1'b0;
    tick();
    check("basic_fd_fall", fd, 1'b0);
    check("basic_so_idle", so, 8'h00);
    for (int i = 0; i < tbl.size(); i++)
      read_byte(tbl[i].ch, tbl[i].exp, $sformatf("basic_rd%0d", i));
    check("basic_all_empty", empty, 4'hF);
    check("basic_no_err", err, 1'b0);

    // Underflow on an empty channel; err must survive a following frame.
    read_byte(0, 8'h00, "uflow_rxd_hold");
    check("uflow_err", err, 1'b1);
    ch_len = {12'd5, 12'd0, 12'd0, 12'd0};
    ch_id  = {16'hABCD, 48'h0};
    run_frame("f2", n);
    check("f2_fd_cycle", n, 10 + TRL);
    check("f2_err_sticky", err, 1'b1);
    drain_ch(3, 16'hABCD, 5, "f2");

    // Reset mid-frame while channel 1 is in its data phase.
    ch_len = {12'd0, 12'd0, 12'h040, 12'd0};
    ch_id  = {32'h0, 16'h7788, 16'h0};
    fs = 1'b1;
    repeat (8) tick();
    check("abort_partial", empty[1], 1'b0);
    rst = 1'b1;
    #1;
    check("abort_empty", empty, 4'hF);
    check("abort_fd", fd, 1'b0);
    check("abort_so", so, 8'h00);
    check("abort_err", err, 1'b0);
    tick();
    rst = 1'b0;
    fs = 1'b0;
    tick();

    // Clean frame after abort, with an fs 0->1 restart attempt during RUN.
    ch_len = {12'd5, 12'd0, 12'd0, 12'd0};
    ch_id  = {16'h0F0E, 48'h0};
    fs = 1'b1;
    repeat (3) tick();
    check("restart_in_run", so, 8'h02);
    fs = 1'b0;
    tick();
    fs = 1'b1;
    tick();
    check("restart_err", err, 1'b1);
    wait_fd("restart_fd_rise", 100, n);
    fs = 1'b0;
    tick();
    check("restart_ch_empty", empty, 4'b0111);
    drain_ch(3, 16'h0F0E, 5, "restart");

    // Wrap: 300 data bytes on channel 2 drained concurrently, plus a len=1 channel.
    ch_len = {12'd0, 12'd300, 12'd1, 12'd0};
    ch_id  = {16'h0, 16'hBEEF, 16'h0102, 16'h0};
    e = frame_bytes(16'hBEEF, 300);
    fs = 1'b1;
    idx = 0; pend = 1'b0; full_seen = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (pend && idx < e.size()) begin
        check($sformatf("wrap_b%0d", idx), rxd[23:16], e[idx]);
        idx++;
      end
      if (full[2]) full_seen = 1'b1;
      if (idx == e.size() && fd) break;
      rxen[2] = ~empty[2];
      pend = rxen[2];
    end
    rxen = '0;
    check("wrap_count", idx, e.size());
    check("wrap_no_full", full_seen, 1'b0);
    check("wrap_fd", fd, 1'b1);
    fs = 1'b0;
    tick();
    check("wrap_ch2_empty", empty[2], 1'b1);
    drain_ch(1, 16'h0102, 1, "len1");

    // Backpressure on the 16-deep instance.
    s_len = 12'd40;
    s_id  = 16'h5A5A;
    s_fs  = 1'b1;
    repeat (30) tick();
    check("bp_full", s_full, 1'b1);
    check("bp_stalled_run", s_so, 8'h02);
    check("bp_no_fd", s_fd, 1'b0);
    e = frame_bytes(16'h5A5A, 40);
    for (int i = 0; i < e.size(); i++) s_read(e[i], $sformatf("bp_b%0d", i));
    n = 0;
    while (!s_fd && n < 20) begin
      tick();
      n++;
    end
    check("bp_fd", s_fd, 1'b1);
    check("bp_drained", s_empty, 1'b1);
    check("bp_no_err", s_err, 1'b0);
    s_fs = 1'b0;
    tick();
    check("bp_fd_fall", s_fd, 1'b0);

`ifdef INTAN_FIFO_SUM_EN
    // Trailer values: 0^1^2^3 = 0x00, 0^1^2 = 0x03.
    ch_len = {12'd0, 12'd0, 12'd3, 12'd4};
    ch_id  = {32'h0, 16'h5678, 16'h1234};
    run_frame("sum", n);
    read_byte(0, 8'h12, "sum4_idhi");
    read_byte(0, 8'h34, "sum4_idlo");
    read_byte(0, 8'h00, "sum4_d0");
    read_byte(0, 8'h01, "sum4_d1");
    read_byte(0, 8'h02, "sum4_d2");
    read_byte(0, 8'h03, "sum4_d3");
    read_byte(0, 8'h00, "sum4_trailer");
    read_byte(1, 8'h56, "sum3_idhi");
    read_byte(1, 8'h78, "sum3_idlo");
    read_byte(1, 8'h00, "sum3_d0");
    read_byte(1, 8'h01, "sum3_d1");
    read_byte(1, 8'h02, "sum3_d2");
    read_byte(1, 8'h03, "sum3_trailer");
    check("sum_empty", empty, 4'hF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
